// File: rtl/lossy_fifo_reader.sv
// Overwrite-on-full FIFO with a registered pop output and a saturating drop counter.
// A write into a full buffer advances both pointers, so the oldest word is discarded.
module lossy_fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int DROP_CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic                       wr,
   input  logic                       rd,
   output logic [DATA_WIDTH-1:0]      dout,
   output logic                       dout_valid,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       dropped,
   output logic [DROP_CNT_W-1:0]      drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wrPtr_q, wrPtr_d;
   logic [PW-1:0]         rdPtr_q, rdPtr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  doutValid_q, doutValid_d;
   logic                  dropped_q, dropped_d;
   logic [DROP_CNT_W-1:0] dropCount_q, dropCount_d;
   logic                  popOk;

   assign popOk = rd && !empty_q;

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      dout_d      = dout_q;
      doutValid_d = 1'b0;
      dropped_d   = 1'b0;
      dropCount_d = dropCount_q;

      if (wr) begin
         wrPtr_d = wrPtr_q + PW'(1);
      end

      if (popOk) begin
         dout_d      = mem_q[rdPtr_q];
         doutValid_d = 1'b1;
         rdPtr_d     = rdPtr_q + PW'(1);
      end

      // A simultaneous write and pop leaves occupancy unchanged, even when full.
      if (wr && !popOk) begin
         if (full_q) begin
            rdPtr_d   = rdPtr_q + PW'(1);
            dropped_d = 1'b1;
            if (dropCount_q != '1) begin
               dropCount_d = dropCount_q + DROP_CNT_W'(1);
            end
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (!wr && popOk) begin
         count_d = count_q - CW'(1);
      end

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         dout_q      <= '0;
         doutValid_q <= 1'b0;
         dropped_q   <= 1'b0;
         dropCount_q <= '0;
      end else begin
         if (wr) begin
            mem_q[wrPtr_q] <= din;
         end
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         dout_q      <= dout_d;
         doutValid_q <= doutValid_d;
         dropped_q   <= dropped_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = doutValid_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign count      = count_q;
   assign dropped    = dropped_q;
   assign drop_count = dropCount_q;

endmodule

// File: tb/tb_lossy_fifo_reader.sv
// Directed bench for lossy_fifo_reader; a second instance with a 2-bit drop counter
// shares the same stimulus so saturation can be observed.
module tb_lossy_fifo_reader;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       wr;
   logic       rd;
   logic       clkRun;

   logic [7:0]  dout;
   logic        doutValid;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        dropped;
   logic [15:0] dropCount;

   logic [7:0]  sDout;
   logic        sDoutValid;
   logic        sFull;
   logic        sEmpty;
   logic [2:0]  sCount;
   logic        sDropped;
   logic [1:0]  sDropCount;

   int assertCount = 0;
   int failCount   = 0;

   lossy_fifo_reader #(.DATA_WIDTH(8), .DEPTH(4), .DROP_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd),
      .dout(dout), .dout_valid(doutValid), .full(full), .empty(empty),
      .count(count), .dropped(dropped), .drop_count(dropCount)
   );

   lossy_fifo_reader #(.DATA_WIDTH(8), .DEPTH(4), .DROP_CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd),
      .dout(sDout), .dout_valid(sDoutValid), .full(sFull), .empty(sEmpty),
      .count(sCount), .dropped(sDropped), .drop_count(sDropCount)
   );

   // Free-running clock that can be held low to exercise reset without edges.
   initial clk = 1'b0;
   always begin
      #5;
      if (clkRun) clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [7:0] v);
      wr = 1'b1; din = v; rd = 1'b0;
      step();
      wr = 1'b0;
   endtask

   task automatic test_reset();
      clkRun = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
      reset = 1'b1;
      #3;
      assertCount++; if (empty !== 1'b1) begin failCount++; $display("[TB] FAIL rst_empty got %b want 1", empty); end
      assertCount++; if (full !== 1'b0) begin failCount++; $display("[TB] FAIL rst_full got %b want 0", full); end
      assertCount++; if (count !== 3'd0) begin failCount++; $display("[TB] FAIL rst_count got %0d want 0", count); end
      assertCount++; if (dout !== 8'h00) begin failCount++; $display("[TB] FAIL rst_dout got %h want 00", dout); end
      assertCount++; if (doutValid !== 1'b0 || dropped !== 1'b0) begin failCount++; $display("[TB] FAIL rst_pulses got valid=%b dropped=%b want 0 0", doutValid, dropped); end
      assertCount++; if (dropCount !== 16'd0) begin failCount++; $display("[TB] FAIL rst_dropcount got %0d want 0", dropCount); end
      reset = 1'b0;
      #2;
      clkRun = 1'b1;
      rd = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         assertCount++; if (doutValid !== 1'b0 || count !== 3'd0) begin failCount++; $display("[TB] FAIL idle_rd got valid=%b count=%0d want 0 0", doutValid, count); end
      end
      rd = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
      for (int i = 0; i < 4; i++) pushWord(exp[i]);
      assertCount++; if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin failCount++; $display("[TB] FAIL fill_flags got full=%b count=%0d empty=%b want 1 4 0", full, count, empty); end
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         assertCount++; if (dout !== exp[i] || doutValid !== 1'b1) begin failCount++; $display("[TB] FAIL drain_%0d got dout=%h valid=%b want %h 1", i, dout, doutValid, exp[i]); end
      end
      rd = 1'b0;
      assertCount++; if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin failCount++; $display("[TB] FAIL drain_empty got empty=%b count=%0d full=%b want 1 0 0", empty, count, full); end
      step();
      assertCount++; if (doutValid !== 1'b0 || dout !== 8'h44) begin failCount++; $display("[TB] FAIL dout_hold got valid=%b dout=%h want 0 44", doutValid, dout); end
   endtask

   task automatic test_overwrite();
      logic [7:0] exp [4];
      exp[0] = 8'h33; exp[1] = 8'h44; exp[2] = 8'h55; exp[3] = 8'h66;
      pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
      assertCount++; if (dropped !== 1'b0) begin failCount++; $display("[TB] FAIL ovw_nodrop got %b want 0", dropped); end
      wr = 1'b1; din = 8'h55;
      step();
      assertCount++; if (dropped !== 1'b1 || dropCount !== 16'd1) begin failCount++; $display("[TB] FAIL ovw_first got dropped=%b cnt=%0d want 1 1", dropped, dropCount); end
      din = 8'h66;
      step();
      wr = 1'b0;
      assertCount++; if (dropped !== 1'b1 || dropCount !== 16'd2 || count !== 3'd4) begin failCount++; $display("[TB] FAIL ovw_second got dropped=%b cnt=%0d count=%0d want 1 2 4", dropped, dropCount, count); end
      step();
      assertCount++; if (dropped !== 1'b0 || dropCount !== 16'd2) begin failCount++; $display("[TB] FAIL ovw_pulse_end got dropped=%b cnt=%0d want 0 2", dropped, dropCount); end
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         assertCount++; if (dout !== exp[i] || doutValid !== 1'b1) begin failCount++; $display("[TB] FAIL ovw_drain_%0d got dout=%h valid=%b want %h 1", i, dout, doutValid, exp[i]); end
      end
      rd = 1'b0;
   endtask

   task automatic test_full_wr_rd();
      logic [7:0] exp [4];
      exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'hAA;
      pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
      wr = 1'b1; rd = 1'b1; din = 8'hAA;
      step();
      wr = 1'b0;
      assertCount++; if (dout !== 8'h11 || doutValid !== 1'b1) begin failCount++; $display("[TB] FAIL fullrw_dout got dout=%h valid=%b want 11 1", dout, doutValid); end
      assertCount++; if (dropped !== 1'b0 || count !== 3'd4 || dropCount !== 16'd2) begin failCount++; $display("[TB] FAIL fullrw_state got dropped=%b count=%0d cnt=%0d want 0 4 2", dropped, count, dropCount); end
      for (int i = 0; i < 4; i++) begin
         step();
         assertCount++; if (dout !== exp[i] || doutValid !== 1'b1) begin failCount++; $display("[TB] FAIL fullrw_drain_%0d got dout=%h valid=%b want %h 1", i, dout, doutValid, exp[i]); end
      end
      rd = 1'b0;
   endtask

   task automatic test_empty_corner();
      logic [7:0] v;
      wr = 1'b1; rd = 1'b1; din = 8'h5A;
      step();
      wr = 1'b0;
      assertCount++; if (doutValid !== 1'b0 || count !== 3'd1 || dout !== 8'hAA) begin failCount++; $display("[TB] FAIL empty_wrrd got valid=%b count=%0d dout=%h want 0 1 AA", doutValid, count, dout); end
      step();
      rd = 1'b0;
      assertCount++; if (dout !== 8'h5A || doutValid !== 1'b1 || empty !== 1'b1) begin failCount++; $display("[TB] FAIL empty_pop got dout=%h valid=%b empty=%b want 5A 1 1", dout, doutValid, empty); end
      // Ten push/pop pairs walk both pointers around the ring more than twice.
      for (int i = 0; i < 10; i++) begin
         v = 8'hC0 + 8'(i);
         pushWord(v);
         rd = 1'b1;
         step();
         rd = 1'b0;
         assertCount++; if (dout !== v || doutValid !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_%0d got dout=%h valid=%b want %h 1", i, dout, doutValid, v); end
      end
   endtask

   task automatic test_mid_reset_sat();
      logic [7:0] exp [4];
      exp[0] = 8'h06; exp[1] = 8'h07; exp[2] = 8'h08; exp[3] = 8'h09;
      pushWord(8'hE1); pushWord(8'hE2); pushWord(8'hE3);
      assertCount++; if (count !== 3'd3 || dropCount !== 16'd2) begin failCount++; $display("[TB] FAIL pre_reset got count=%0d cnt=%0d want 3 2", count, dropCount); end
      #1;
      reset = 1'b1;
      #1;
      assertCount++; if (count !== 3'd0 || dropCount !== 16'd0 || empty !== 1'b1) begin failCount++; $display("[TB] FAIL mid_reset got count=%0d cnt=%0d empty=%b want 0 0 1", count, dropCount, empty); end
      assertCount++; if (sCount !== 3'd0 || sDropCount !== 2'd0 || dout !== 8'h00) begin failCount++; $display("[TB] FAIL mid_reset_sat got count=%0d cnt=%0d dout=%h want 0 0 00", sCount, sDropCount, dout); end
      @(negedge clk);
      reset = 1'b0;
      rd = 1'b1;
      step();
      rd = 1'b0;
      assertCount++; if (doutValid !== 1'b0 || count !== 3'd0) begin failCount++; $display("[TB] FAIL post_reset_rd got valid=%b count=%0d want 0 0", doutValid, count); end
      for (int i = 1; i <= 4; i++) pushWord(8'(i));
      for (int k = 1; k <= 5; k++) begin
         wr = 1'b1; din = 8'(4 + k);
         step();
         wr = 1'b0;
         assertCount++; if (sDropped !== 1'b1 || sDropCount !== ((k > 3) ? 2'd3 : 2'(k))) begin failCount++; $display("[TB] FAIL sat_%0d got dropped=%b cnt=%0d want 1 %0d", k, sDropped, sDropCount, (k > 3) ? 3 : k); end
         assertCount++; if (dropCount !== 16'(k)) begin failCount++; $display("[TB] FAIL wide_cnt_%0d got %0d want %0d", k, dropCount, k); end
      end
      step();
      assertCount++; if (sDropped !== 1'b0 || sDropCount !== 2'd3) begin failCount++; $display("[TB] FAIL sat_hold got dropped=%b cnt=%0d want 0 3", sDropped, sDropCount); end
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         assertCount++; if (sDout !== exp[i] || dout !== exp[i]) begin failCount++; $display("[TB] FAIL sat_drain_%0d got %h/%h want %h", i, dout, sDout, exp[i]); end
      end
      rd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overwrite();
      test_full_wr_rd();
      test_empty_corner();
      test_mid_reset_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/lossy_fifo_reader.md
Name: lossy_fifo_reader

Overview:
- Read-side companion to the team's overwrite-on-full write buffer.
- Holds up to DEPTH words; the write side never stalls.
- A write into a full buffer discards the oldest word and counts the loss.
- A consumer pops words through a rd strobe and receives each one on a registered output with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 4, number of entries; power of two, at least 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  write data.
- wr  input  1  write strobe; always accepted.
- rd  input  1  pop request; ignored when empty.
- dout  output  DATA_WIDTH  registered popped word; holds its value between pops.
- dout_valid  output  1  one-cycle pulse, high the cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current occupancy.
- dropped  output  1  one-cycle pulse, high the cycle after an overwrite.
- drop_count  output  DROP_CNT_W  total overwrites since reset; saturates at all-ones.

Behaviour:
- Reset (asynchronous, takes effect immediately, with or without a clock):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - dout=0, dout_valid=0, dropped=0, drop_count=0, storage cleared to 0.
  - Reset asserted mid-operation discards all contents. The first edge after deassertion behaves as on an empty buffer.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Accepted pop: pop_ok = rd && !empty, evaluated on pre-edge state.
- Per rising edge, with state sampled before the edge:
  - wr=0, pop_ok=0: hold all state. dout_valid=0, dropped=0.
  - wr=1, !full, pop_ok=0:
    - mem[wr_ptr]<=din, wr_ptr++, count++.
  - wr=1, full, pop_ok=0 (overwrite):
    - mem[wr_ptr]<=din, wr_ptr++, rd_ptr++; count stays DEPTH.
    - dropped<=1; drop_count++ unless already saturated.
  - wr=0, pop_ok=1:
    - dout<=mem[rd_ptr], dout_valid<=1, rd_ptr++, count--.
  - wr=1, pop_ok=1 (any non-empty count, including full):
    - Pop the old head: dout<=mem[rd_ptr], dout_valid<=1, rd_ptr++.
    - Write din at wr_ptr, wr_ptr++.
    - count unchanged; no drop.
  - rd=1 while empty: no pop and dout_valid=0. A same-cycle write is stored normally; there is no bypass from din to dout.
- full and empty are registered, consistent with count every cycle, and never both high.
- Latency:
  - A word written at edge N is poppable at edge N+1.
  - A pop at edge N presents the word on dout, with dout_valid=1, in cycle N+1.
- dout updates only on an accepted pop; otherwise it retains the last popped value.
- dropped and dout_valid are single-cycle pulses; back-to-back events give consecutive high cycles.
- FIFO order is preserved. After an overwrite, the next pop returns the oldest surviving word.

Test Plan (DEPTH=4, DATA_WIDTH=8):
- Reset then idle:
  - Assert reset with clk stopped → outputs go to reset values immediately: empty=1, count=0, dout=0.
  - Release reset; rd=1 for 2 cycles → dout_valid stays 0, count stays 0.
- Fill and drain:
  - Write 0x11, 0x22, 0x33, 0x44 → full=1, count=4.
  - Then rd=1 for 4 cycles → dout 0x11, 0x22, 0x33, 0x44, each with dout_valid=1.
  - After the fourth pop → empty=1.
- Overwrite:
  - Fill with 0x11..0x44, then write 0x55 and 0x66 → dropped pulses twice, drop_count=2, count=4.
  - Drain → 0x33, 0x44, 0x55, 0x66.
- Simultaneous wr+rd when full:
  - Full with 0x11..0x44; wr=1 din=0xAA with rd=1 → next cycle dout=0x11, dropped=0, count=4.
  - Drain → 0x22, 0x33, 0x44, 0xAA.
- Empty-side corner and wrap:
  - wr=1 din=0x5A with rd=1 while empty → no dout_valid, count=1.
  - Next rd → dout=0x5A.
  - Run 10 push/pop pairs to wrap the pointers twice → data order intact.
- Mid-operation reset and saturation:
  - Assert reset with count=3 → count=0 and drop_count=0 immediately.
  - With DROP_CNT_W=2, perform 5 overwrites → drop_count saturates at 3 while dropped still pulses on each overwrite.
